mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/cond_negate.sv | 14 +
 rtl/mul_div_unit.sv | 169 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states, default width.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/cond_negate.sv
// Two's-complement negate when en is set, pass-through otherwise.
module cond_negate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  output logic [WIDTH-1:0] result_c
);

  always_comb begin
    result_c = en ? (~data + WIDTH'(1)) : data;
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: sign-magnitude core, one radix-2 step per cycle,
// sign fix-up in a final cycle.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  input  logic             i_flush,
  input  logic             i_hi_we,
  input  logic             i_lo_we,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_dz
);

  logic [1:0]         state, state_nxt;
  logic               accept_c, step_c, fix_c;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opr;
  logic               is_div_q, neg_a_q, neg_r_q, dz_pend_q;

  logic               div_op_c, s1_c, s2_c, dz_c;
  logic [WIDTH-1:0]   abs1_c, abs2_c;
  logic [WIDTH:0]     mul_sum_c, rem_sh_c, diff_c;
  logic [2*WIDTH-1:0] mul_step_c, div_step_c, prod_fix_c;
  logic [WIDTH-1:0]   quo_fix_c, rem_fix_c;

  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q, dz_q;

  // Operand decode at the start cycle
  always_comb begin
    div_op_c = op_is_div(i_op);
    s1_c     = op_is_signed(i_op) & i_op1[WIDTH-1];
    s2_c     = op_is_signed(i_op) & i_op2[WIDTH-1];
    dz_c     = div_op_c & (i_op2 == '0);
  end

  cond_negate #(.WIDTH(WIDTH)) u_abs1 (.data(i_op1), .en(s1_c), .result_c(abs1_c));
  cond_negate #(.WIDTH(WIDTH)) u_abs2 (.data(i_op2), .en(s2_c), .result_c(abs2_c));

  // One shift-add multiply step and one restoring divide step on the accumulator
  always_comb begin
    mul_sum_c  = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opr})
                        : {1'b0, acc[2*WIDTH-1:WIDTH]};
    mul_step_c = {mul_sum_c, acc[WIDTH-1:1]};
    rem_sh_c   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff_c     = rem_sh_c - {1'b0, opr};
    div_step_c = diff_c[WIDTH] ? {rem_sh_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                               : {diff_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  cond_negate #(.WIDTH(2*WIDTH)) u_fix_prod (.data(acc), .en(neg_a_q), .result_c(prod_fix_c));
  cond_negate #(.WIDTH(WIDTH)) u_fix_quo (.data(acc[WIDTH-1:0]), .en(neg_a_q), .result_c(quo_fix_c));
  cond_negate #(.WIDTH(WIDTH)) u_fix_rem (.data(acc[2*WIDTH-1:WIDTH]), .en(neg_r_q),
                                          .result_c(rem_fix_c));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Flush wins over start in IDLE and suppresses the FIX write-back
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    step_c    = 1'b0;
    fix_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start && !i_flush) begin
          state_nxt = ST_CALC;
          accept_c  = 1'b1;
        end
      end
      ST_CALC: begin
        if (i_flush) begin
          state_nxt = ST_IDLE;
        end else begin
          step_c = 1'b1;
          if (cnt == CNT_W'(1)) state_nxt = ST_FIX;
        end
      end
      ST_FIX: begin
        state_nxt = ST_IDLE;
        fix_c     = !i_flush;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Divide-by-zero preloads the result image and holds it through CALC
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt       <= '0;
      acc       <= '0;
      opr       <= '0;
      is_div_q  <= 1'b0;
      neg_a_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      dz_pend_q <= 1'b0;
    end else if (accept_c) begin
      cnt       <= CNT_W'(WIDTH);
      is_div_q  <= div_op_c;
      neg_r_q   <= s1_c;
      dz_pend_q <= dz_c;
      opr       <= div_op_c ? abs2_c : abs1_c;
      if (dz_c) begin
        neg_a_q <= 1'b0;
        acc     <= {abs1_c, {WIDTH{1'b1}}};
      end else if (div_op_c) begin
        neg_a_q <= s1_c ^ s2_c;
        acc     <= {{WIDTH{1'b0}}, abs1_c};
      end else begin
        neg_a_q <= s1_c ^ s2_c;
        acc     <= {{WIDTH{1'b0}}, abs2_c};
      end
    end else if (step_c) begin
      cnt <= cnt - CNT_W'(1);
      if (!dz_pend_q) acc <= is_div_q ? div_step_c : mul_step_c;
    end else if (state_nxt == ST_IDLE) begin
      cnt <= '0;
    end
  end

  // Architectural HI/LO, direct writes only while idle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      dz_q   <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      done_q <= fix_c;
      busy_q <= (state_nxt != ST_IDLE);
      if (fix_c) begin
        if (is_div_q) begin
          hi_q <= rem_fix_c;
          lo_q <= quo_fix_c;
        end else begin
          {hi_q, lo_q} <= prod_fix_c;
        end
        dz_q <= dz_pend_q;
      end else if (state == ST_IDLE) begin
        if (i_hi_we) hi_q <= i_wdata;
        if (i_lo_we) lo_q <= i_wdata;
      end
    end
  end

  assign o_hi   = hi_q;
  assign o_lo   = lo_q;
  assign o_dz   = dz_q;
  assign o_done = done_q;
  assign o_busy = busy_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed corner cases plus random ops against a plain-arithmetic model.
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned W8 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, flush, hi_we, lo_we;
  logic [1:0]    op;
  logic [W-1:0]  op1, op2, wdata, hi, lo;
  logic          busy, done, dz;

  logic          rst8, start8;
  logic [1:0]    op8;
  logic [W8-1:0] a8, b8, hi8, lo8;
  logic          busy8, done8, dz8;

  int n_cmp = 0;
  int n_bad = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_op1(op1), .i_op2(op2),
    .i_flush(flush), .i_hi_we(hi_we), .i_lo_we(lo_we), .i_wdata(wdata),
    .o_busy(busy), .o_done(done), .o_hi(hi), .o_lo(lo), .o_dz(dz)
  );

  mul_div_unit #(.WIDTH(W8)) dut8 (
    .i_clk(clk), .i_rst(rst8), .i_start(start8), .i_op(op8), .i_op1(a8), .i_op2(b8),
    .i_flush(1'b0), .i_hi_we(1'b0), .i_lo_we(1'b0), .i_wdata(8'h00),
    .o_busy(busy8), .o_done(done8), .o_hi(hi8), .o_lo(lo8), .o_dz(dz8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference results from signed/unsigned 64-bit arithmetic
  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] rhi, output logic [W-1:0] rlo,
                                output logic rdz);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    rdz = 1'b0;
    rhi = '0;
    rlo = '0;
    case (o)
      OP_MULT:  begin p = 64'(sa * sb); {rhi, rlo} = p; end
      OP_MULTU: begin p = {32'h0, a} * {32'h0, b}; {rhi, rlo} = p; end
      OP_DIV: begin
        if (b == '0) begin rlo = '1; rhi = a; rdz = 1'b1; end
        else begin q = sa / sb; r = sa % sb; rlo = W'(q); rhi = W'(r); end
      end
      default: begin
        if (b == '0) begin rlo = '1; rhi = a; rdz = 1'b1; end
        else begin rlo = a / b; rhi = a % b; end
      end
    endcase
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h1;
      2:       return '1;
      3:       return 32'h8000_0000;
      4:       return W'($urandom_range(0, 100));
      default: return $urandom;
    endcase
  endfunction

  task automatic watch_no_done(input int n, input string tag);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check(tag, seen, 0);
  endtask

  // poke: stray start mid-operation; wr: HI/LO write in the start cycle
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit poke, input bit wr, input string tag);
    logic [W-1:0] ehi, elo, wv;
    logic         edz;
    int           lat;
    model(o, a, b, ehi, elo, edz);
    wv    = $urandom;
    start = 1'b1; op = o; op1 = a; op2 = b;
    if (wr) begin hi_we = 1'b1; lo_we = 1'b1; wdata = wv; end
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op1 = $urandom; op2 = $urandom; op = 2'($urandom);
    check({tag, "_busy"}, busy, 1);
    if (wr) begin
      check({tag, "_wrhi"}, hi, wv);
      check({tag, "_wrlo"}, lo, wv);
    end
    lat = 0;
    while (!done && lat < 40) begin
      start = poke && (lat == 4);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({tag, "_lat"}, lat, 33);
    check({tag, "_hi"}, hi, ehi);
    check({tag, "_lo"}, lo, elo);
    check({tag, "_dz"}, dz, edz);
    check({tag, "_idle"}, busy, 0);
    @(negedge clk);
    check({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    logic [W-1:0] v, prev_hi, prev_lo;
    int           lat;
    logic         seen;

    rst = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = OP_MULT; op1 = '0; op2 = '0; wdata = '0;
    rst8 = 1'b1; start8 = 1'b0; op8 = OP_DIV; a8 = '0; b8 = '0;
    #1;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", dz, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; rst8 = 1'b0;

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 0, 0, "mult_m3x7");
    check("mult_m3x7_hi_k", hi, 32'hFFFF_FFFF);
    check("mult_m3x7_lo_k", lo, 32'hFFFF_FFEB);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "multu_max");
    check("multu_max_hi_k", hi, 32'hFFFF_FFFE);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, "div_m7d2");
    check("div_m7d2_lo_k", lo, 32'hFFFF_FFFD);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div_ovf");
    check("div_ovf_lo_k", lo, 32'h8000_0000);
    run_op(OP_DIVU, 32'd7, 32'd0, 0, 0, "divu_dz");
    check("divu_dz_dz_k", dz, 1);
    run_op(OP_MULTU, 32'd2, 32'd3, 0, 0, "multu_2x3");
    check("multu_2x3_lo_k", lo, 32'd6);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, 0, 0, "div_neg_dz");

    // Direct HI/LO writes while idle
    v = $urandom; prev_lo = lo;
    hi_we = 1'b1; wdata = v;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_hi", hi, v);
    check("mthi_lo", lo, prev_lo);
    v = $urandom; prev_hi = hi;
    lo_we = 1'b1; wdata = v;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_lo", lo, v);
    check("mtlo_hi", hi, prev_hi);

    // Flush mid-CALC with an ignored LO write while busy
    prev_hi = hi; prev_lo = lo;
    start = 1'b1; op = OP_MULT; op1 = $urandom; op2 = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    lo_we = 1'b1; wdata = ~prev_lo;
    @(negedge clk);
    lo_we = 1'b0;
    check("busy_we_lo", lo, prev_lo);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_hi", hi, prev_hi);
    check("flush_lo", lo, prev_lo);
    watch_no_done(40, "flush_nodone");
    check("flush_hi_late", hi, prev_hi);

    // Flush in IDLE overrides start
    start = 1'b1; flush = 1'b1; op = OP_DIVU; op1 = 32'd9; op2 = 32'd2;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("idle_flush_busy", busy, 0);
    watch_no_done(40, "idle_flush_nodone");

    run_op(OP_DIVU, 32'd100, 32'd7, 0, 1, "wr_and_start");
    run_op(OP_MULT, 32'h1234_5678, 32'h8765_4321, 1, 0, "start_ignored");

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick(), (i % 5) == 0, (i % 7) == 0,
             $sformatf("rnd%0d", i));
    end

    // Narrow instance: DIV -128/3 latency and result, then async reset mid-operation
    start8 = 1'b1; op8 = OP_DIV; a8 = 8'h80; b8 = 8'h03;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h55; b8 = 8'h00;
    lat = 0;
    while (!done8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("w8_lat", lat, 9);
    check("w8_lo", lo8, 8'hD6);
    check("w8_hi", hi8, 8'hFE);
    check("w8_dz", dz8, 0);

    start8 = 1'b1; op8 = OP_MULT; a8 = 8'h7F; b8 = 8'h7F;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("w8_busy_pre", busy8, 1);
    #2 rst8 = 1'b1;
    #1;
    check("w8_rst_hi", hi8, 0);
    check("w8_rst_lo", lo8, 0);
    check("w8_rst_busy", busy8, 0);
    check("w8_rst_done", done8, 0);
    check("w8_rst_dz", dz8, 0);
    @(negedge clk);
    rst8 = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done8 || busy8) seen = 1'b1;
    end
    check("w8_rst_nodone", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
